// File: rtl/ysyx_040066_csr_trap_unit.sv
// ysyx_040066_csr_trap_unit: M-mode CSR file with prioritised trap/interrupt redirect control
module ysyx_040066_csr_trap_unit #(
  parameter int XLEN      = 64,
  parameter int HART_ID   = 0,
  parameter int VECTOR_EN = 1,
  parameter int CNT_EN    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_rd_addr,
  output logic [XLEN-1:0] csr_rd_data,
  output logic            csr_rd_err,
  input  logic            csr_wr_en,
  input  logic [11:0]     csr_wr_addr,
  input  logic [XLEN-1:0] csr_wr_data,
  output logic            csr_wr_err,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            irq_take,
  input  logic            mret,
  input  logic            instret,
  input  logic            irq_mtip,
  input  logic            irq_msip,
  input  logic            irq_meip,
  output logic            irq_pending,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mstatus_mie
);
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305, A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC = 12'h341, A_MCAUSE = 12'h342, A_MTVAL = 12'h343, A_MIP = 12'h344;
  localparam logic [11:0] A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02, A_MHARTID = 12'hF14;
  // UXL/SXL (64-bit only) and MPP=M are hardwired; truncation drops UXL/SXL for XLEN=32
  localparam logic [XLEN-1:0] MST_FIXED = XLEN'(64'hA_0000_1800);
  localparam logic [XLEN-1:0] LOW2 = XLEN'(3);
  logic st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d, mtval_q, mtval_d, mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [2:0] irq_q, irq_d;
  logic [XLEN-1:0] mip, mstatus, enabled, base, wv, rd_val;
  logic [3:0] code;
  logic is_cnt, wr_store, wr_known, tvec_ok, take, do_exc, do_irq, do_wr, rd_ok;

  assign irq_d = {irq_meip, irq_mtip, irq_msip};
  assign mip = (XLEN'(irq_q[2]) << 11) | (XLEN'(irq_q[1]) << 7) | (XLEN'(irq_q[0]) << 3);
  assign mstatus = MST_FIXED | (XLEN'(st_mpie_q) << 7) | (XLEN'(st_mie_q) << 3);
  assign enabled = mip & mie_q;
  assign irq_pending = st_mie_q & |enabled;
  assign mstatus_mie = st_mie_q;
  assign code = enabled[11] ? 4'd11 : enabled[3] ? 4'd3 : 4'd7;
  assign base = mtvec_q & ~LOW2;
  assign take = irq_take & irq_pending;
  assign do_exc = exc_valid & ~mret;
  assign do_irq = take & ~mret & ~exc_valid;
  assign redirect = exc_valid | irq_take | mret;
  assign redirect_pc = mret ? mepc_q :
                       (do_irq && mtvec_q[1:0] == 2'b01) ? base + XLEN'({code, 2'b00}) : base;

  assign is_cnt = csr_wr_addr inside {A_MCYCLE, A_MINSTRET};
  assign wr_store = (csr_wr_addr inside {A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL}) ||
                    (is_cnt && CNT_EN != 0);
  // mip and disabled counters swallow writes silently; only mhartid and unknown addresses fault
  assign wr_known = wr_store || is_cnt || csr_wr_addr == A_MIP;
  assign csr_wr_err = csr_wr_en & ~wr_known;
  assign do_wr = csr_wr_en & wr_store & ~mret & ~exc_valid & ~take;
  assign tvec_ok = csr_wr_data[1:0] == 2'b00 || (VECTOR_EN != 0 && csr_wr_data[1:0] == 2'b01);
  assign wv = (csr_wr_addr == A_MSTATUS) ? MST_FIXED | (csr_wr_data & XLEN'(12'h088)) :
              (csr_wr_addr == A_MIE)     ? csr_wr_data & XLEN'(12'h888) :
              (csr_wr_addr == A_MTVEC)   ? (tvec_ok ? csr_wr_data : csr_wr_data & ~LOW2) :
              (csr_wr_addr == A_MEPC)    ? csr_wr_data & ~LOW2 : csr_wr_data;

  always_comb begin
    rd_val = '0;
    rd_ok = 1'b1;
    case (csr_rd_addr)
      A_MSTATUS:  rd_val = mstatus;
      A_MIE:      rd_val = mie_q;
      A_MTVEC:    rd_val = mtvec_q;
      A_MSCRATCH: rd_val = mscratch_q;
      A_MEPC:     rd_val = mepc_q;
      A_MCAUSE:   rd_val = mcause_q;
      A_MTVAL:    rd_val = mtval_q;
      A_MIP:      rd_val = mip;
      A_MCYCLE:   rd_val = (CNT_EN != 0) ? mcycle_q : '0;
      A_MINSTRET: rd_val = (CNT_EN != 0) ? minstret_q : '0;
      A_MHARTID:  rd_val = XLEN'(HART_ID);
      default:    rd_ok = 1'b0;
    endcase
  end

  assign csr_rd_err = ~rd_ok;
  assign csr_rd_data = (do_wr && csr_wr_addr == csr_rd_addr) ? wv : rd_val;

  always_comb begin
    st_mie_d = st_mie_q;
    st_mpie_d = st_mpie_q;
    mie_d = mie_q;
    mtvec_d = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d = mepc_q;
    mcause_d = mcause_q;
    mtval_d = mtval_q;
    mcycle_d = mcycle_q + XLEN'(1);
    minstret_d = minstret_q + XLEN'(instret);
    if (mret) begin
      st_mie_d = st_mpie_q;
      st_mpie_d = 1'b1;
    end else if (do_exc || do_irq) begin
      st_mpie_d = st_mie_q;
      st_mie_d = 1'b0;
      mepc_d = trap_pc & ~LOW2;
      mcause_d = do_exc ? XLEN'(exc_cause) : {1'b1, {(XLEN-5){1'b0}}, code};
      mtval_d = do_exc ? exc_tval : '0;
    end else if (do_wr) begin
      case (csr_wr_addr)
        A_MSTATUS: begin
          st_mie_d = wv[3];
          st_mpie_d = wv[7];
        end
        A_MIE:      mie_d = wv;
        A_MTVEC:    mtvec_d = wv;
        A_MSCRATCH: mscratch_d = wv;
        A_MEPC:     mepc_d = wv;
        A_MCAUSE:   mcause_d = wv;
        A_MTVAL:    mtval_d = wv;
        A_MCYCLE:   mcycle_d = wv;
        A_MINSTRET: minstret_d = wv;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie_q <= 1'b0;
      st_mpie_q <= 1'b0;
      mie_q <= '0;
      mtvec_q <= '0;
      mscratch_q <= '0;
      mepc_q <= '0;
      mcause_q <= '0;
      mtval_q <= '0;
      mcycle_q <= '0;
      minstret_q <= '0;
      irq_q <= '0;
    end else begin
      st_mie_q <= st_mie_d;
      st_mpie_q <= st_mpie_d;
      mie_q <= mie_d;
      mtvec_q <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q <= mtval_d;
      mcycle_q <= mcycle_d;
      minstret_q <= minstret_d;
      irq_q <= irq_d;
    end
  end
endmodule

// File: tb/tb_ysyx_040066_csr_trap_unit.sv
// tb_ysyx_040066_csr_trap_unit: directed and random checks of the CSR/trap unit against a CSR-map model
module tb_ysyx_040066_csr_trap_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, wr_en, rd_err, wr_err, exc_valid, irq_take, mret, instret;
  logic mtip, msip, meip, irq_pending, redirect, mstatus_mie;
  logic [11:0] rd_addr, wr_addr;
  logic [63:0] rd_data, wr_data, exc_tval, trap_pc, redirect_pc;
  logic [3:0] exc_cause;

  ysyx_040066_csr_trap_unit #(.XLEN(64), .HART_ID(0), .VECTOR_EN(1), .CNT_EN(1)) dut (
    .clk(clk), .rst(rst), .csr_rd_addr(rd_addr), .csr_rd_data(rd_data), .csr_rd_err(rd_err),
    .csr_wr_en(wr_en), .csr_wr_addr(wr_addr), .csr_wr_data(wr_data), .csr_wr_err(wr_err),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .trap_pc(trap_pc),
    .irq_take(irq_take), .mret(mret), .instret(instret), .irq_mtip(mtip), .irq_msip(msip),
    .irq_meip(meip), .irq_pending(irq_pending), .redirect(redirect), .redirect_pc(redirect_pc),
    .mstatus_mie(mstatus_mie)
  );

  logic s_rst, s_wr_en, s_rd_err, s_wr_err, s_irq_take, s_mtip, s_pend, s_redir, s_mie;
  logic [11:0] s_rd_addr, s_wr_addr;
  logic [31:0] s_rd_data, s_wr_data, s_trap_pc, s_redir_pc;

  ysyx_040066_csr_trap_unit #(.XLEN(32), .HART_ID(0), .VECTOR_EN(0), .CNT_EN(1)) dut32 (
    .clk(clk), .rst(s_rst), .csr_rd_addr(s_rd_addr), .csr_rd_data(s_rd_data), .csr_rd_err(s_rd_err),
    .csr_wr_en(s_wr_en), .csr_wr_addr(s_wr_addr), .csr_wr_data(s_wr_data), .csr_wr_err(s_wr_err),
    .exc_valid(1'b0), .exc_cause(4'd0), .exc_tval(32'd0), .trap_pc(s_trap_pc),
    .irq_take(s_irq_take), .mret(1'b0), .instret(1'b0), .irq_mtip(s_mtip), .irq_msip(1'b0),
    .irq_meip(1'b0), .irq_pending(s_pend), .redirect(s_redir), .redirect_pc(s_redir_pc),
    .mstatus_mie(s_mie)
  );

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural CSR map: every implemented CSR held as the value software would read
  localparam logic [63:0] MST_RST = 64'hA_0000_1800;
  logic [63:0] csr [logic [11:0]];
  logic [11:0] impl [$] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                             12'h344, 12'hB00, 12'hB02, 12'hF14};
  logic [11:0] rda [$] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                            12'h344, 12'hB00, 12'hB02, 12'hF14, 12'h7C0, 12'h301, 12'h000};
  logic [11:0] wra [$] = '{12'h300, 12'h300, 12'h304, 12'h304, 12'h305, 12'h340, 12'h341,
                            12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hF14, 12'h7C0};

  function automatic bit writable(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hB00, 12'hB02};
  endfunction

  function automatic bit known(input logic [11:0] a);
    return writable(a) || a == 12'h344 || a == 12'hF14;
  endfunction

  function automatic logic [63:0] legal(input logic [11:0] a, input logic [63:0] d);
    case (a)
      12'h300: return MST_RST | (d & 64'h88);
      12'h304: return d & 64'h888;
      12'h305: return (d % 4 > 1) ? d - d % 4 : d;
      12'h341: return d - d % 4;
      default: return d;
    endcase
  endfunction

  function automatic void m_reset();
    foreach (impl[i]) csr[impl[i]] = 64'd0;
    csr[12'h300] = MST_RST;
  endfunction

  function automatic bit m_pending();
    logic [63:0] st = csr[12'h300];
    return st[3] && ((csr[12'h344] & csr[12'h304]) != 0);
  endfunction

  function automatic int m_code();
    logic [63:0] en = csr[12'h344] & csr[12'h304];
    return en[11] ? 11 : en[3] ? 3 : 7;
  endfunction

  function automatic bit m_effwr();
    return wr_en && writable(wr_addr) && !mret && !exc_valid && !(irq_take && m_pending());
  endfunction

  function automatic void m_trap(input logic [63:0] cause, input logic [63:0] tval);
    logic [63:0] st = csr[12'h300];
    st[7] = st[3];
    st[3] = 1'b0;
    csr[12'h300] = st;
    csr[12'h341] = trap_pc - trap_pc % 4;
    csr[12'h342] = cause;
    csr[12'h343] = tval;
  endfunction

  task automatic compare();
    logic [63:0] st = csr[12'h300];
    logic [63:0] tv = csr[12'h305];
    logic [63:0] erd, epc;
    erd = !known(rd_addr) ? 64'd0 : (m_effwr() && wr_addr == rd_addr) ? legal(wr_addr, wr_data) : csr[rd_addr];
    epc = mret ? csr[12'h341] :
          (tv - tv % 4) + ((!exc_valid && irq_take && m_pending() && tv % 4 == 1) ? 64'(4 * m_code()) : 64'd0);
    check("rd_data", rd_data, erd);
    check("rd_err", rd_err, !known(rd_addr));
    check("wr_err", wr_err, wr_en && !(writable(wr_addr) || wr_addr == 12'h344));
    check("irq_pending", irq_pending, m_pending());
    check("mstatus_mie", mstatus_mie, st[3]);
    check("redirect", redirect, exc_valid || irq_take || mret);
    check("redirect_pc", redirect_pc, epc);
  endtask

  function automatic void m_step();
    logic [63:0] st = csr[12'h300];
    bit pend = m_pending(), ew = m_effwr();
    int code = m_code();
    if (rst) begin
      m_reset();
      return;
    end
    csr[12'hB00] = csr[12'hB00] + 1;
    csr[12'hB02] = csr[12'hB02] + (instret ? 1 : 0);
    if (mret) begin
      st[3] = st[7];
      st[7] = 1'b1;
      csr[12'h300] = st;
    end else if (exc_valid) m_trap(64'(exc_cause), exc_tval);
    else if (irq_take && pend) m_trap((64'd1 << 63) | 64'(code), 64'd0);
    else if (ew) csr[wr_addr] = legal(wr_addr, wr_data);
    csr[12'h344] = (64'(meip) << 11) | (64'(mtip) << 7) | (64'(msip) << 3);
  endfunction

  task automatic cyc();
    #1;
    compare();
    m_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic tick32();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    {wr_en, exc_valid, irq_take, mret, instret, mtip, msip, meip} = '0;
    rd_addr = 12'h0; wr_addr = 12'h0; wr_data = '0; exc_cause = '0; exc_tval = '0; trap_pc = '0;
    {s_wr_en, s_irq_take, s_mtip} = '0;
    s_rst = 1'b1; s_rd_addr = 12'h0; s_wr_addr = 12'h0; s_wr_data = '0; s_trap_pc = '0;
    rst = 1'b1;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd_addr = 12'hB00; #1;
    check("rst_mcycle", rd_data, 64'd0);
    check("rst_pending", irq_pending, 1'b0);
    check("rst_mie_bit", mstatus_mie, 1'b0);
    cyc();
    rd_addr = 12'h300; #1;
    check("rst_mstatus", rd_data, 64'hA_0000_1800);
    cyc();
    rd_addr = 12'h304; #1;
    check("rst_mie", rd_data, 64'd0);
    cyc();
    rd_addr = 12'h7C0; wr_en = 1'b1; wr_addr = 12'hF14; wr_data = 64'd5; #1;
    check("unimpl_rd_err", rd_err, 1'b1);
    check("unimpl_rd_data", rd_data, 64'd0);
    check("hartid_wr_err", wr_err, 1'b1);
    cyc();
    wr_en = 1'b0;
    wr(12'h305, 64'h8000_0001);
    wr(12'h304, 64'h888);
    wr(12'h300, 64'h8);
    mtip = 1'b1; meip = 1'b1;
    cyc();
    #1;
    check("irq_pend_set", irq_pending, 1'b1);
    irq_take = 1'b1; trap_pc = 64'h100; #1;
    check("irq_redirect", redirect, 1'b1);
    check("irq_vec_pc", redirect_pc, 64'h8000_002C);
    cyc();
    irq_take = 1'b0;
    rd_addr = 12'h342; #1;
    check("irq_mcause", rd_data, 64'h8000_0000_0000_000B);
    cyc();
    rd_addr = 12'h341; #1;
    check("irq_mepc", rd_data, 64'h100);
    check("irq_mie_clr", mstatus_mie, 1'b0);
    cyc();
    rd_addr = 12'h300; #1;
    check("irq_mpie", rd_data, 64'hA_0000_1880);
    cyc();
    mret = 1'b1; #1;
    check("mret1_pc", redirect_pc, 64'h100);
    cyc();
    mret = 1'b0;
    exc_valid = 1'b1; exc_cause = 4'd11; exc_tval = 64'd0; irq_take = 1'b1; trap_pc = 64'h200;
    mtip = 1'b0; meip = 1'b0; #1;
    check("exc_irq_pend", irq_pending, 1'b1);
    check("exc_direct_pc", redirect_pc, 64'h8000_0000);
    cyc();
    exc_valid = 1'b0; irq_take = 1'b0;
    rd_addr = 12'h342; #1;
    check("exc_mcause", rd_data, 64'd11);
    cyc();
    mret = 1'b1; #1;
    check("mret2_pc", redirect_pc, 64'h200);
    cyc();
    mret = 1'b0; #1;
    check("mret2_mie", mstatus_mie, 1'b1);
    wr(12'h341, 64'h1003);
    rd_addr = 12'h341; #1;
    check("mepc_warl", rd_data, 64'h1000);
    wr(12'h305, 64'h8000_0002);
    rd_addr = 12'h305; #1;
    check("mtvec_warl", rd_data, 64'h8000_0000);
    wr_en = 1'b1; wr_addr = 12'h344; wr_data = 64'hFFF; rd_addr = 12'h344; #1;
    check("mip_wr_err", wr_err, 1'b0);
    check("mip_no_bypass", rd_data, 64'd0);
    cyc();
    wr_en = 1'b0; #1;
    check("mip_unchanged", rd_data, 64'd0);
    wr(12'hB00, '1);
    rd_addr = 12'hB00; #1;
    check("mcycle_written", rd_data, '1);
    cyc();
    #1;
    check("mcycle_wrap", rd_data, 64'd0);
    wr_en = 1'b1; wr_addr = 12'hB02; wr_data = 64'd5; instret = 1'b1;
    cyc();
    wr_en = 1'b0; instret = 1'b0;
    rd_addr = 12'hB02; #1;
    check("minstret_wr_wins", rd_data, 64'd5);
    cyc();
    for (int n = 0; n < 1500; n++) begin
      rst = $urandom_range(0, 99) == 0;
      rd_addr = rda[$urandom_range(0, rda.size() - 1)];
      wr_en = $urandom_range(0, 2) == 0;
      wr_addr = wra[$urandom_range(0, wra.size() - 1)];
      wr_data = {$urandom, $urandom};
      mret = $urandom_range(0, 19) == 0;
      exc_valid = $urandom_range(0, 24) == 0;
      exc_cause = 4'($urandom);
      exc_tval = {$urandom, $urandom};
      trap_pc = {$urandom, $urandom};
      irq_take = $urandom_range(0, 5) == 0;
      mtip = $urandom_range(0, 2) == 0;
      msip = $urandom_range(0, 2) == 0;
      meip = $urandom_range(0, 3) == 0;
      instret = 1'($urandom);
      cyc();
    end
    {rst, wr_en, exc_valid, irq_take, mret, instret} = '0;
    s_rst = 1'b0; s_rd_addr = 12'h300; #1;
    check("x32_mstatus_rst", s_rd_data, 32'h1800);
    s_wr_en = 1'b1; s_wr_addr = 12'h305; s_wr_data = 32'h1;
    tick32();
    s_wr_addr = 12'h304; s_wr_data = 32'h80;
    tick32();
    s_wr_addr = 12'h300; s_wr_data = 32'h8; s_mtip = 1'b1;
    tick32();
    s_wr_en = 1'b0; s_rd_addr = 12'h305; #1;
    check("x32_mtvec_mode", s_rd_data, 32'h0);
    check("x32_pending", s_pend, 1'b1);
    s_irq_take = 1'b1; s_trap_pc = 32'h40; #1;
    check("x32_redirect_pc", s_redir_pc, 32'h0);
    tick32();
    s_irq_take = 1'b0; s_rd_addr = 12'h342; #1;
    check("x32_mcause", s_rd_data, 32'h8000_0007);
    tick32();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
